// File: rtl/subtractor_mc.sv
// rtl/subtractor_mc.sv - multi-cycle unsigned subtractor with borrow, W bits per cycle
// Optional zero/ovf flag outputs are built only when SUBTRACTOR_MC_FLAGS_EN is defined.
module subtractor_mc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bo
`ifdef SUBTRACTOR_MC_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam int K  = N / W;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("subtractor_mc: W must divide N and satisfy 1 <= W <= N");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          br_q, br_d;
  logic [N-1:0]  d_q, d_d;
  logic          bo_q, bo_d;

  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W:0]    diff;
  logic [N-1:0]  d_run;
  logic          last;

`ifdef SUBTRACTOR_MC_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    a_chunk = a_q[k_q*W +: W];
    b_chunk = b_q[k_q*W +: W];
    // The top bit of the W+1-bit difference is the borrow into the next chunk.
    diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{W{1'b0}}, br_q};
    last    = (k_q == KW'(K - 1));
    d_run   = d_q;
    d_run[k_q*W +: W] = diff[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    d_d     = d_q;
    bo_d    = bo_q;
`ifdef SUBTRACTOR_MC_FLAGS_EN
    // Flags are only non-zero while a result is being presented.
    zero_d  = (state_q == S_DONE && !out_ready) ? zero_q : 1'b0;
    ovf_d   = (state_q == S_DONE && !out_ready) ? ovf_q  : 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bi;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        d_d  = d_run;
        br_d = diff[W];
        k_d  = k_q + 1'b1;
        if (last) begin
          k_d     = '0;
          bo_d    = diff[W];
          state_d = S_DONE;
`ifdef SUBTRACTOR_MC_FLAGS_EN
          zero_d  = (d_run == '0);
          ovf_d   = (a_q[N-1] != b_q[N-1]) && (d_run[N-1] != a_q[N-1]);
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
`ifdef SUBTRACTOR_MC_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
`ifdef SUBTRACTOR_MC_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign d         = d_q;
  assign bo        = bo_q;
`ifdef SUBTRACTOR_MC_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_mc.sv
// tb/tb_subtractor_mc.sv - self-checking bench for subtractor_mc
// Flag checks are compiled in only when SUBTRACTOR_MC_FLAGS_EN is defined.
module tb_subtractor_mc;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
    logic        zero;
    logic        ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rrst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bi;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bo;
  logic        zero;
  logic        ovf;

  always #5 clk = ~clk;

  subtractor_mc #(.N(16), .W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef SUBTRACTOR_MC_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

`ifndef SUBTRACTOR_MC_FLAGS_EN
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Accept one operation and wait for out_valid; lat counts cycles from the accept edge.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibi, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_op", in_ready, 1);
    in_valid = 1'b1;
    a  = ia;
    b  = ib;
    bi = ibi;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    bi = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", in_ready, 1);
    check("out_valid_after_handshake", out_valid, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int cnt;
    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    rrst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bi = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_d", d, 0);
    check("reset_bo", bo, 0);
    check("reset_zero", zero, 0);
    check("reset_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rrst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_d", i), d, vecs[i].d);
      check($sformatf("vec%0d_bo", i), bo, vecs[i].bo);
      check($sformatf("vec%0d_in_ready_done", i), in_ready, 0);
`ifdef SUBTRACTOR_MC_FLAGS_EN
      check($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
      release_result();
    end

    // Consumer stall: result must hold while in_valid pulses are ignored.
    run_op(16'h1234, 16'h0034, 1'b0, lat);
    check("stall_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'h0001;
      bi = 1'b1;
      check("stall_out_valid", out_valid, 1);
      check("stall_d", d, 16'h1200);
      check("stall_bo", bo, 0);
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    run_op(16'h0000, 16'h0001, 1'b0, lat);
    check("post_stall_d", d, 16'hFFFF);
    check("post_stall_bo", bo, 1);
    release_result();

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    bi = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrun_not_done", out_valid, 0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_d", d, 0);
    check("abort_bo", bo, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("post_abort_idle_in_ready", in_ready, 1);
      check("post_abort_no_result", out_valid, 0);
    end
    run_op(16'h00FF, 16'h0F00, 1'b0, lat);
    check("post_abort_latency", lat, 4);
    check("post_abort_d", d, 16'hF1FF);
    check("post_abort_bo", bo, 1);
    release_result();

    cnt = 0;
    while (!(rnd[0].done && rnd[1].done && rnd[2].done) && cnt < 70000) begin
      @(negedge clk);
      cnt++;
    end
    check("random_streams_finished", {31'b0, rnd[0].done && rnd[1].done && rnd[2].done}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Random traffic against the arithmetic model for several (N, W) shapes.
  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int RN = (g == 2) ? 16 : 8;
    localparam int RW = (g == 0) ? 1 : ((g == 1) ? 8 : 4);
    localparam int NOPS = 2000;

    logic          riv;
    logic          rin_ready;
    logic [RN-1:0] ra;
    logic [RN-1:0] rb;
    logic          rbi;
    logic          rout_valid;
    logic          ror;
    logic [RN-1:0] rd;
    logic          rbo;
    logic          rzero;
    logic          rovf;
    logic          done;
    logic [RN:0]   expq[$];
    logic [RN-1:0] expa[$];
    logic [RN-1:0] expb[$];

    subtractor_mc #(.N(RN), .W(RW)) u_rdut (
      .clk       (clk),
      .rst       (rrst),
      .in_valid  (riv),
      .in_ready  (rin_ready),
      .a         (ra),
      .b         (rb),
      .bi        (rbi),
      .out_valid (rout_valid),
      .out_ready (ror),
      .d         (rd),
      .bo        (rbo)
`ifdef SUBTRACTOR_MC_FLAGS_EN
      ,
      .zero      (rzero),
      .ovf       (rovf)
`endif
    );

`ifndef SUBTRACTOR_MC_FLAGS_EN
    assign rzero = 1'b0;
    assign rovf  = 1'b0;
`endif

    initial begin
      int ops;
      int cyc;
      logic [RN:0]   m;
      logic [RN:0]   e;
      logic [RN-1:0] ea;
      logic [RN-1:0] eb;
      done = 1'b0;
      riv = 1'b0;
      ror = 1'b0;
      ra = '0;
      rb = '0;
      rbi = 1'b0;
      ops = 0;
      cyc = 0;
      #1;
      while (rrst) @(negedge clk);
      while (ops < NOPS && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        riv = ($urandom_range(0, 1) == 1);
        ra  = RN'($urandom);
        rb  = RN'($urandom);
        rbi = 1'($urandom_range(0, 1));
        ror = ($urandom_range(0, 2) != 0);
        if (riv && rin_ready) begin
          m = {1'b0, ra} - {1'b0, rb} - (RN+1)'(rbi);
          expq.push_back(m);
          expa.push_back(ra);
          expb.push_back(rb);
        end
        if (rout_valid && ror) begin
          if (expq.size() == 0) begin
            check($sformatf("rnd%0d_unexpected_result", g), 1, 0);
          end else begin
            e  = expq.pop_front();
            ea = expa.pop_front();
            eb = expb.pop_front();
            check($sformatf("rnd%0d_d", g), 32'(rd), 32'(e[RN-1:0]));
            check($sformatf("rnd%0d_bo", g), rbo, e[RN]);
`ifdef SUBTRACTOR_MC_FLAGS_EN
            check($sformatf("rnd%0d_zero", g), rzero, (e[RN-1:0] == '0));
            check($sformatf("rnd%0d_ovf", g), rovf,
                  (ea[RN-1] != eb[RN-1]) && (e[RN-1] != ea[RN-1]));
`endif
            ops++;
          end
        end
      end
      riv = 1'b0;
      check($sformatf("rnd%0d_ops_completed", g), ops, NOPS);
      done = 1'b1;
    end
  end

endmodule
